// File: rtl/iadc_pkg.sv
// iadc_pkg: shared types and elaboration-time helpers for the incremental-ADC
// back-end (conversion state encoding, decimator order limits, width helpers).
package iadc_pkg;

  // Conversion sequence states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MRST  = 3'd1,
    INTEG = 3'd2,
    LATCH = 3'd3,
    SHOUT = 3'd4
  } state_t;

  // Supported decimator orders.
  localparam int ORDER_MIN = 1;
  localparam int ORDER_MAX = 2;

  function automatic bit order_ok(input int order);
    return (order >= ORDER_MIN) && (order <= ORDER_MAX);
  endfunction

  // Accumulator width: an ORDER-stage integrator chain over at most
  // 2^OSR_W-1 one-bit samples never exceeds this many bits.
  function automatic int acc_w(input int order, input int osr_w);
    return order * osr_w + 1;
  endfunction

  // Shared phase counter must hold osr-1, RST_CYC-1 and DATA_W-1.
  function automatic int cnt_w(input int osr_w, input int rst_cyc, input int data_w);
    int w;
    w = osr_w;
    if ($clog2(rst_cyc + 1) > w) w = $clog2(rst_cyc + 1);
    if ($clog2(data_w + 1) > w) w = $clog2(data_w + 1);
    return w;
  endfunction

endpackage

// File: rtl/iadc_coi_decim.sv
// iadc_coi_decim: ORDER-stage cascade-of-integrators decimator for the 1-bit
// modulator stream, with a right-shift and saturating output stage.
//   clk, rst   : clock, synchronous active-high reset
//   clr        : synchronous clear of all accumulators
//   en         : accumulate bit_in at this edge
//   bit_in     : modulator comparator bit
//   word, sat  : combinational shifted/saturated result of the final stage
module iadc_coi_decim
  import iadc_pkg::*;
#(
  parameter int DATA_W    = 12,
  parameter int OSR_W     = 10,
  parameter int ORDER     = 2,
  parameter int OUT_SHIFT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic              bit_in,
  output logic [DATA_W-1:0] word,
  output logic              sat
);

  localparam int ACC_W = acc_w(ORDER, OSR_W);
  // Zero-extended by DATA_W so the overflow test works even when DATA_W > ACC_W.
  localparam int EXT_W = ACC_W + DATA_W;

  if (!order_ok(ORDER)) begin : g_order_bad
    $error("iadc_coi_decim: ORDER must be 1 or 2");
  end

  logic [ACC_W-1:0] acc1_r;
  logic [ACC_W-1:0] acc2_r;
  logic [ACC_W-1:0] acc1_nx_s;
  logic [ACC_W-1:0] accf_s;
  logic [EXT_W-1:0] ext_s;

  // Second stage integrates the first stage value including the current bit.
  assign acc1_nx_s = acc1_r + {{(ACC_W-1){1'b0}}, bit_in};

  // Integrator chain registers.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc1_r <= {ACC_W{1'b0}};
      acc2_r <= {ACC_W{1'b0}};
    end else if (en) begin
      acc1_r <= acc1_nx_s;
      acc2_r <= acc2_r + acc1_nx_s;
    end else begin
      acc1_r <= acc1_r;
      acc2_r <= acc2_r;
    end
  end

  assign accf_s = (ORDER == 1) ? acc1_r : acc2_r;
  assign ext_s  = {{DATA_W{1'b0}}, accf_s} >> OUT_SHIFT;

  // Any set bit above the output word means the result does not fit.
  assign sat  = |ext_s[EXT_W-1:DATA_W];
  assign word = sat ? {DATA_W{1'b1}} : ext_s[DATA_W-1:0];

endmodule

// File: rtl/iadc_ctrl.sv
// iadc_ctrl: incremental-ADC digital back-end. Sequences modulator reset,
// integration and latch, decimates the bitstream and shifts the result out
// MSB first (or streams raw mod_in in debug mode).
//   clk, rst            : clock, synchronous active-high reset
//   start, cont, osr    : conversion request, continuous mode, oversampling ratio
//   debug, mod_in       : raw-bitstream mode, modulator comparator bit
//   mod_rst, mod_en     : modulator integrator reset / integrate window
//   busy                : any state but IDLE
//   data_out, sat       : last result and its saturation flag
//   data_valid          : one-cycle pulse when data_out updates
//   shift, serial_data_out : serial result stream with per-bit strobe
module iadc_ctrl
  import iadc_pkg::*;
#(
  parameter int DATA_W    = 12,
  parameter int OSR_W     = 10,
  parameter int ORDER     = 2,
  parameter int RST_CYC   = 2,
  parameter int OUT_SHIFT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cont,
  input  logic [OSR_W-1:0]  osr,
  input  logic              debug,
  input  logic              mod_in,
  output logic              mod_rst,
  output logic              mod_en,
  output logic              busy,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              sat,
  output logic              shift,
  output logic              serial_data_out
);

  localparam int CNT_W = cnt_w(OSR_W, RST_CYC, DATA_W);

  state_t             state_r;
  state_t             state_nx_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   cnt_nx_s;
  logic               capture_s;
  logic [OSR_W-1:0]   osr_q_r;
  logic [DATA_W-1:0]  word_s;
  logic               sat_s;
  logic [DATA_W-1:0]  shreg_r;
  logic               serial_nx_s;
  logic               mod_rst_r;
  logic               mod_en_r;
  logic               busy_r;
  logic [DATA_W-1:0]  data_out_r;
  logic               data_valid_r;
  logic               sat_r;
  logic               shift_r;
  logic               serial_r;

  // State and phase counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
    end
  end

  // Next-state and counter logic; capture_s marks every entry into MRST.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    capture_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nx_s = MRST;
          cnt_nx_s   = {CNT_W{1'b0}};
          capture_s  = 1'b1;
        end else begin
          state_nx_s = IDLE;
        end
      end
      MRST: begin
        if (cnt_r == CNT_W'(RST_CYC - 1)) begin
          state_nx_s = INTEG;
          cnt_nx_s   = {CNT_W{1'b0}};
        end else begin
          cnt_nx_s = cnt_r + CNT_W'(1);
        end
      end
      INTEG: begin
        // osr_q_r is never 0, so the subtraction cannot underflow.
        if (cnt_r == CNT_W'(osr_q_r) - CNT_W'(1)) begin
          state_nx_s = LATCH;
          cnt_nx_s   = {CNT_W{1'b0}};
        end else begin
          cnt_nx_s = cnt_r + CNT_W'(1);
        end
      end
      LATCH: begin
        state_nx_s = SHOUT;
        cnt_nx_s   = {CNT_W{1'b0}};
      end
      SHOUT: begin
        if (cnt_r == CNT_W'(DATA_W - 1)) begin
          cnt_nx_s = {CNT_W{1'b0}};
          if (cont) begin
            state_nx_s = MRST;
            capture_s  = 1'b1;
          end else begin
            state_nx_s = IDLE;
          end
        end else begin
          cnt_nx_s = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_nx_s = IDLE;
        cnt_nx_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Accumulators are held clear until integration starts.
  iadc_coi_decim #(
    .DATA_W   (DATA_W),
    .OSR_W    (OSR_W),
    .ORDER    (ORDER),
    .OUT_SHIFT(OUT_SHIFT)
  ) u_decim (
    .clk   (clk),
    .rst   (rst),
    .clr   ((state_r == IDLE) || (state_r == MRST)),
    .en    (state_r == INTEG),
    .bit_in(mod_in),
    .word  (word_s),
    .sat   (sat_s)
  );

  // Next serial bit: raw input in debug, else the result MSB-first while in SHOUT.
  always_comb begin
    serial_nx_s = 1'b0;
    if (debug) begin
      serial_nx_s = mod_in;
    end else if (state_r == LATCH) begin
      serial_nx_s = word_s[DATA_W-1];
    end else if ((state_r == SHOUT) && (state_nx_s == SHOUT)) begin
      serial_nx_s = shreg_r[DATA_W-1];
    end else begin
      serial_nx_s = 1'b0;
    end
  end

  // Registered outputs, osr capture and result shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      osr_q_r      <= {OSR_W{1'b0}};
      shreg_r      <= {DATA_W{1'b0}};
      mod_rst_r    <= 1'b0;
      mod_en_r     <= 1'b0;
      busy_r       <= 1'b0;
      data_out_r   <= {DATA_W{1'b0}};
      data_valid_r <= 1'b0;
      sat_r        <= 1'b0;
      shift_r      <= 1'b0;
      serial_r     <= 1'b0;
    end else begin
      if (capture_s) begin
        osr_q_r <= (osr == {OSR_W{1'b0}}) ? {{(OSR_W-1){1'b0}}, 1'b1} : osr;
      end
      // Outputs follow the state being entered so they line up with it.
      mod_rst_r    <= (state_nx_s == MRST);
      mod_en_r     <= (state_nx_s == INTEG);
      busy_r       <= (state_nx_s != IDLE);
      data_valid_r <= (state_r == LATCH);
      shift_r      <= (state_nx_s == SHOUT) && !debug;
      serial_r     <= serial_nx_s;
      if (state_r == LATCH) begin
        data_out_r <= word_s;
        sat_r      <= sat_s;
        // MSB leaves via serial_r now; the shifter holds the remaining bits.
        shreg_r    <= {word_s[DATA_W-2:0], 1'b0};
      end else if (state_r == SHOUT) begin
        shreg_r <= {shreg_r[DATA_W-2:0], 1'b0};
      end
    end
  end

  assign mod_rst         = mod_rst_r;
  assign mod_en          = mod_en_r;
  assign busy            = busy_r;
  assign data_out        = data_out_r;
  assign data_valid      = data_valid_r;
  assign sat             = sat_r;
  assign shift           = shift_r;
  assign serial_data_out = serial_r;

endmodule
